// File: rtl/restador_pkg.sv
// Shared types and defaults for the serial subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state type, default width/chunk sizes, signed-overflow helper.
package restador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 16;

  // Two's-complement overflow of a - b: only possible when the operand signs
  // differ, and shows up as a result whose sign disagrees with the minuend.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/restador_chunk.sv
// One CHUNK-wide slice of the subtractor: d_k = a_k + ~b_k + cin.
// Latency: combinational.
// Backpressure: none.
//
// Ports: a_k/b_k operand slices, cin carry-in (inverted borrow),
//        d_k difference slice, cout carry-out (inverted borrow-out).
module restador_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a_k,
  input  logic [CHUNK-1:0] b_k,
  input  logic             cin,
  output logic [CHUNK-1:0] d_k,
  output logic             cout
);

  logic [CHUNK:0] sum;

  assign sum  = {1'b0, a_k} + {1'b0, ~b_k} + {{CHUNK{1'b0}}, cin};
  assign d_k  = sum[CHUNK-1:0];
  assign cout = sum[CHUNK];

endmodule

// File: rtl/restador_64bit_serial.sv
// Serial subtractor: diff = a - b - bin, CHUNK bits per cycle, LSB chunk first.
// Latency: result valid NCHUNK cycles after the operand handshake; one op in flight.
// Backpressure: out_ready=0 holds the result stable in DONE; in_ready is low until it drains.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, bin;
//        out_valid/out_ready with diff, bout (unsigned borrow-out), ovf (signed overflow).
module restador_64bit_serial
  import restador_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("CHUNK must divide WIDTH");
  end

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic             bout_r, ovf_r;

  // Chunked views of the operand and result registers so the counter can
  // select a slice by plain array indexing.
  logic [CHUNK-1:0] a_ch [NCHUNK];
  logic [CHUNK-1:0] b_ch [NCHUNK];
  logic [CHUNK-1:0] d_ch [NCHUNK];

  logic [CHUNK-1:0] a_k, b_k, d_k;
  logic             cout;
  logic             accept, last;

  for (genvar g = 0; g < NCHUNK; g++) begin : g_slice
    assign a_ch[g]                   = a_r[g*CHUNK +: CHUNK];
    assign b_ch[g]                   = b_r[g*CHUNK +: CHUNK];
    assign diff[g*CHUNK +: CHUNK]    = d_ch[g];
  end

  assign a_k = a_ch[cnt];
  assign b_k = b_ch[cnt];

  restador_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_k  (a_k),
    .b_k  (b_k),
    .cin  (carry),
    .d_k  (d_k),
    .cout (cout)
  );

  assign accept = (state == IDLE) && in_valid;
  assign last   = (state == CALC) && (cnt == LAST);
  assign bout   = bout_r;
  assign ovf    = ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      carry  <= 1'b0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
      for (int i = 0; i < NCHUNK; i++) d_ch[i] <= '0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      // a - b - bin == a + ~b + (1 - bin), so the first carry is ~bin.
      carry <= ~bin;
      cnt   <= '0;
    end else if (state == CALC) begin
      d_ch[cnt] <= d_k;
      carry     <= cout;
      cnt       <= cnt + 1'b1;
      if (last) begin
        bout_r <= ~cout;
        // d_k[CHUNK-1] is the result MSB; diff's register is not yet updated.
        ovf_r  <= sub_ovf(a_r[WIDTH-1], b_r[WIDTH-1], d_k[CHUNK-1]);
      end
    end
  end

endmodule

// File: tb/tb_restador_64bit_serial.sv
module tb_restador_64bit_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        ovf;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  restador_64bit_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision unsigned and signed arithmetic.
  task automatic model(input logic [63:0] va, input logic [63:0] vb, input logic vbin,
                       output logic [63:0] d, output logic bo, output logic ov);
    logic [64:0]        u;
    logic signed [65:0] s;
    u  = {1'b0, va} - {1'b0, vb} - {64'd0, vbin};
    d  = u[63:0];
    bo = u[64];
    s  = $signed({{2{va[63]}}, va}) - $signed({{2{vb[63]}}, vb}) - $signed({65'd0, vbin});
    ov = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
  endtask

  // Present operands at a negedge and return right after the accepting posedge.
  task automatic start_op(input logic [63:0] va, input logic [63:0] vb, input logic vbin);
    @(negedge clk);
    a        = va;
    b        = vb;
    bin      = vbin;
    in_valid = 1'b1;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
  endtask

  // Called right after the accepting edge; returns at a negedge with out_valid=1.
  task automatic wait_result(input logic [63:0] ed, input logic eb, input logic eo);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      if (cyc == 0) begin
        in_valid = 1'b0;
        check("in_ready_busy", 64'(in_ready), 64'd0);
      end
      cyc++;
    end while (!out_valid && cyc < 20);
    check("latency", 64'(cyc - 1), 64'd4);
    check("diff", diff, ed);
    check("bout", 64'(bout), 64'(eb));
    check("ovf", 64'(ovf), 64'(eo));
    check("in_ready_done", 64'(in_ready), 64'd0);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drained", 64'(out_valid), 64'd0);
    check("in_ready_after", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] ra, rb, ed, ed2;
    logic        rbin, eb, eo, eb2, eo2;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_diff", diff, 64'd0);
    check("rst_bout", 64'(bout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal
    start_op(64'h0123456789abcdef, 64'h00ffffffffffff00, 1'b0);
    wait_result(64'h0023456789abceef, 1'b0, 1'b0);
    release_out();

    // Unsigned underflow
    start_op(64'h0, 64'h1, 1'b0);
    wait_result(64'hffffffffffffffff, 1'b1, 1'b0);
    release_out();

    // Signed overflow
    start_op(64'h8000000000000000, 64'h1, 1'b0);
    wait_result(64'h7fffffffffffffff, 1'b0, 1'b1);
    release_out();

    // Borrow-in
    start_op(64'h5, 64'h5, 1'b1);
    wait_result(64'hffffffffffffffff, 1'b1, 1'b0);
    release_out();
    start_op(64'h10, 64'h1, 1'b1);
    wait_result(64'he, 1'b0, 1'b0);
    release_out();

    // Backpressure for 10 cycles, then back-to-back accept
    ra = {$urandom(), $urandom()};
    rb = {$urandom(), $urandom()};
    model(ra, rb, 1'b0, ed, eb, eo);
    start_op(ra, rb, 1'b0);
    wait_result(ed, eb, eo);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_diff", diff, ed);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    ra   = {$urandom(), $urandom()};
    rb   = {$urandom(), $urandom()};
    rbin = 1'($urandom_range(0, 1));
    model(ra, rb, rbin, ed2, eb2, eo2);
    out_ready = 1'b1;
    a         = ra;
    b         = rb;
    bin       = rbin;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_out_valid", 64'(out_valid), 64'd0);
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    wait_result(ed2, eb2, eo2);
    release_out();

    // Reset in the middle of CALC
    start_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_diff", diff, 64'd0);
    check("mid_rst_bout", 64'(bout), 64'd0);
    check("mid_rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_result", 64'(out_valid), 64'd0);
    end
    ra = {$urandom(), $urandom()};
    rb = {$urandom(), $urandom()};
    model(ra, rb, 1'b1, ed, eb, eo);
    start_op(ra, rb, 1'b1);
    wait_result(ed, eb, eo);
    release_out();

    // Randomized operations with random backpressure
    for (int n = 0; n < 40; n++) begin
      ra   = {$urandom(), $urandom()};
      rb   = {$urandom(), $urandom()};
      rbin = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ;
        1: rb = ra;
        2: begin ra = 64'($urandom_range(0, 3)); rb = 64'($urandom_range(0, 3)); end
        default: begin ra[63] = 1'b1; rb[63] = 1'b0; end
      endcase
      model(ra, rb, rbin, ed, eb, eo);
      start_op(ra, rb, rbin);
      wait_result(ed, eb, eo);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("rnd_hold_diff", diff, ed);
      end
      release_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
